// File: rtl/imuldiv_pkg.sv
// Shared op encoding for the integer multiply/divide unit; the decoder uses the same values.
package imuldiv_pkg;

    localparam int unsigned IMDOP_WIDTH = 4;

    localparam logic [IMDOP_WIDTH-1:0] IMDOP_NONE  = 4'd0;
    localparam logic [IMDOP_WIDTH-1:0] IMDOP_MULT  = 4'd1;
    localparam logic [IMDOP_WIDTH-1:0] IMDOP_MULTU = 4'd2;
    localparam logic [IMDOP_WIDTH-1:0] IMDOP_DIV   = 4'd3;
    localparam logic [IMDOP_WIDTH-1:0] IMDOP_DIVU  = 4'd4;
    localparam logic [IMDOP_WIDTH-1:0] IMDOP_MFHI  = 4'd5;
    localparam logic [IMDOP_WIDTH-1:0] IMDOP_MFLO  = 4'd6;
    localparam logic [IMDOP_WIDTH-1:0] IMDOP_MTHI  = 4'd7;
    localparam logic [IMDOP_WIDTH-1:0] IMDOP_MTLO  = 4'd8;

    function automatic logic is_iter_op(input logic [IMDOP_WIDTH-1:0] op);
        return (op == IMDOP_MULT) || (op == IMDOP_MULTU) ||
               (op == IMDOP_DIV)  || (op == IMDOP_DIVU);
    endfunction

endpackage

// File: rtl/imuldiv.sv
// Iterative multiply/divide unit owning HI/LO; one shift-add or restoring-divide step per clock.
module imuldiv
    import imuldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   i_fetch_stall,
    input  logic                   i_mem_stall,
    input  logic [IMDOP_WIDTH-1:0] i_op,
    input  logic [WIDTH-1:0]       i_rs_val,
    input  logic [WIDTH-1:0]       i_rt_val,
    output logic                   o_stall,
    output logic [WIDTH-1:0]       o_rd_val,
    output logic                   o_rd_valid,
    output logic                   o_busy
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_FIX} state_e;

    state_e             state;
    logic [CW-1:0]      counter;
    logic [WIDTH-1:0]   hi, lo, op_b, rs_orig, rd_val;
    logic [2*WIDTH-1:0] acc;
    logic               is_div, neg_q, neg_r, div_zero, busy, rd_valid;

    logic               op_valid, core_stall, accept, signed_op, rs_neg, rt_neg, div_op;
    logic [WIDTH-1:0]   rs_mag, rt_mag, q_fix, r_fix;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] prod_fix;

    always_comb begin
        op_valid   = (i_op != IMDOP_NONE);
        core_stall = i_fetch_stall | i_mem_stall | o_stall;
        accept     = !core_stall && op_valid;
        div_op     = (i_op == IMDOP_DIV) || (i_op == IMDOP_DIVU);
        signed_op  = (i_op == IMDOP_MULT) || (i_op == IMDOP_DIV);
        rs_neg     = signed_op & i_rs_val[WIDTH-1];
        rt_neg     = signed_op & i_rt_val[WIDTH-1];
        rs_mag     = rs_neg ? -i_rs_val : i_rs_val;
        rt_mag     = rt_neg ? -i_rt_val : i_rt_val;

        // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
        mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_b} : '0);
        div_shift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff   = div_shift - {1'b0, op_b};

        prod_fix   = neg_q ? -acc : acc;
        q_fix      = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix      = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= ST_IDLE;
            counter  <= '0;
            hi       <= '0;
            lo       <= '0;
            op_b     <= '0;
            rs_orig  <= '0;
            acc      <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            rd_val   <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (!core_stall) begin
                if (i_op == IMDOP_MFHI) begin
                    rd_val   <= hi;
                    rd_valid <= 1'b1;
                end else if (i_op == IMDOP_MFLO) begin
                    rd_val   <= lo;
                    rd_valid <= 1'b1;
                end else begin
                    rd_valid <= 1'b0;
                end
            end

            unique case (state)
                ST_IDLE: begin
                    if (accept && i_op == IMDOP_MTHI) hi <= i_rs_val;
                    if (accept && i_op == IMDOP_MTLO) lo <= i_rs_val;
                    if (accept && is_iter_op(i_op)) begin
                        state    <= ST_CALC;
                        busy     <= 1'b1;
                        counter  <= '0;
                        is_div   <= div_op;
                        op_b     <= div_op ? rt_mag : rs_mag;
                        acc      <= {{WIDTH{1'b0}}, (div_op ? rs_mag : rt_mag)};
                        neg_q    <= rs_neg ^ rt_neg;
                        neg_r    <= rs_neg;
                        div_zero <= (i_rt_val == '0);
                        rs_orig  <= i_rs_val;
                    end
                end
                ST_CALC: begin
                    if (is_div) begin
                        if (!div_diff[WIDTH])
                            acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        else
                            acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                    counter <= counter + CW'(1);
                    if (counter == LAST_STEP) state <= ST_FIX;
                end
                ST_FIX: begin
                    if (!is_div) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (div_zero) begin
                        hi <= rs_orig;
                        lo <= '1;
                    end else begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end
                    counter <= '0;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_stall    = busy & op_valid;
    assign o_busy     = busy;
    assign o_rd_val   = rd_val;
    assign o_rd_valid = rd_valid;

endmodule

// File: tb/tb_imuldiv.sv
// Self-checking bench for imuldiv: directed corner cases plus random ops against an arithmetic HI/LO model.
module tb_imuldiv;
    import imuldiv_pkg::*;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        i_fetch_stall = 1'b0;
    logic        i_mem_stall = 1'b0;
    logic [3:0]  i_op = IMDOP_NONE;
    logic [31:0] i_rs_val = '0;
    logic [31:0] i_rt_val = '0;
    logic        o_stall, o_rd_valid, o_busy;
    logic [31:0] o_rd_val;

    int total = 0;
    int bad = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    imuldiv #(.WIDTH(32)) dut (
        .clk(clk), .nrst(nrst), .i_fetch_stall(i_fetch_stall), .i_mem_stall(i_mem_stall),
        .i_op(i_op), .i_rs_val(i_rs_val), .i_rt_val(i_rt_val),
        .o_stall(o_stall), .o_rd_val(o_rd_val), .o_rd_valid(o_rd_valid), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    // Called just after a negedge; returns just after the negedge following the accept edge.
    task automatic do_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         output int stall_cycles);
        stall_cycles = 0;
        i_op = op; i_rs_val = rs; i_rt_val = rt;
        #1;
        while (o_stall === 1'b1 && stall_cycles < 200) begin
            @(negedge clk); #1;
            stall_cycles++;
        end
        if (stall_cycles >= 200) begin
            total++; bad++;
            $display("FAIL accept_timeout op=%0d got stall>=%0d need release", op, stall_cycles);
        end
        @(posedge clk);
        @(negedge clk);
        i_op = IMDOP_NONE;
        #1;
    endtask

    task automatic model_apply(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        longint sa, sb, q, r, p;
        longint unsigned up;
        sa = longint'($signed(rs));
        sb = longint'($signed(rt));
        case (op)
            IMDOP_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            IMDOP_MULTU: begin up = {32'd0, rs} * {32'd0, rt}; m_hi = up[63:32]; m_lo = up[31:0]; end
            IMDOP_DIV: begin
                if (rt == 0) begin m_hi = rs; m_lo = 32'hFFFF_FFFF; end
                else begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
            end
            IMDOP_DIVU: begin
                if (rt == 0) begin m_hi = rs; m_lo = 32'hFFFF_FFFF; end
                else begin m_lo = rs / rt; m_hi = rs % rt; end
            end
            IMDOP_MTHI: m_hi = rs;
            IMDOP_MTLO: m_lo = rs;
            default: ;
        endcase
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic test_reset();
        nrst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (o_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b need=0", o_stall); end
        total++; if (o_rd_val !== 32'h0) begin bad++; $display("FAIL reset_rd_val got=%h need=0", o_rd_val); end
        total++; if (o_rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid got=%b need=0", o_rd_valid); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b need=0", o_busy); end
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multu_max();
        int st;
        do_op(IMDOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st);
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL multu_busy got=%b need=1", o_busy); end
        do_op(IMDOP_MFHI, 0, 0, st);
        total++; if (st != 33) begin bad++; $display("FAIL mfhi_stall_cycles got=%0d need=33", st); end
        total++; if (o_rd_valid !== 1'b1 || o_rd_val !== 32'hFFFF_FFFE) begin
            bad++; $display("FAIL multu_hi got=%b/%h need=1/fffffffe", o_rd_valid, o_rd_val); end
        do_op(IMDOP_MFLO, 0, 0, st);
        total++; if (st != 0 || o_rd_val !== 32'h0000_0001) begin
            bad++; $display("FAIL multu_lo got=%0d/%h need=0/00000001", st, o_rd_val); end
        @(negedge clk); #1;
        total++; if (o_rd_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_drop got=%b need=0", o_rd_valid); end
        m_hi = 32'hFFFF_FFFE; m_lo = 32'h1;
    endtask

    task automatic test_directed();
        logic [3:0]  ops [5] = '{IMDOP_MULT, IMDOP_DIV, IMDOP_DIVU, IMDOP_DIV, IMDOP_DIV};
        logic [31:0] rsv [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFF9};
        logic [31:0] rtv [5] = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] ehi [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd0, 32'hFFFF_FFF9};
        logic [31:0] elo [5] = '{32'hFFFF_FFEB, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] got_hi;
        int st;
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], rsv[i], rtv[i], st);
            do_op(IMDOP_MFHI, 0, 0, st);
            got_hi = o_rd_val;
            do_op(IMDOP_MFLO, 0, 0, st);
            total++; if (got_hi !== ehi[i] || o_rd_val !== elo[i]) begin
                bad++; $display("FAIL directed_%0d got hi=%h lo=%h need hi=%h lo=%h", i, got_hi, o_rd_val, ehi[i], elo[i]); end
            m_hi = ehi[i]; m_lo = elo[i];
        end
    endtask

    task automatic test_mthi_mfhi_stall();
        int st;
        do_op(IMDOP_MTHI, 32'h1234, 0, st);
        i_op = IMDOP_MFHI; i_mem_stall = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            total++; if (o_stall !== 1'b0 || o_rd_valid !== 1'b0) begin
                bad++; $display("FAIL mfhi_memstall_%0d got stall=%b valid=%b need 0/0", c, o_stall, o_rd_valid); end
            @(negedge clk); #1;
        end
        i_mem_stall = 1'b0;
        @(posedge clk); @(negedge clk);
        i_op = IMDOP_NONE; i_mem_stall = 1'b1;
        #1;
        total++; if (o_rd_valid !== 1'b1 || o_rd_val !== 32'h1234) begin
            bad++; $display("FAIL mthi_mfhi got=%b/%h need=1/00001234", o_rd_valid, o_rd_val); end
        @(negedge clk); #1;
        total++; if (o_rd_valid !== 1'b1 || o_rd_val !== 32'h1234) begin
            bad++; $display("FAIL rd_hold_stall got=%b/%h need=1/00001234", o_rd_valid, o_rd_val); end
        i_mem_stall = 1'b0;
        @(negedge clk); #1;
        total++; if (o_rd_valid !== 1'b0) begin bad++; $display("FAIL single_accept got=%b need=0", o_rd_valid); end
        m_hi = 32'h1234;
    endtask

    task automatic test_divu_background();
        int st, busy_cycles, stall_seen;
        logic [31:0] got_hi;
        busy_cycles = 0; stall_seen = 0;
        do_op(IMDOP_DIVU, 32'd100, 32'd7, st);
        for (int c = 0; c < 60; c++) begin
            if (o_busy === 1'b1) busy_cycles++;
            if (o_stall !== 1'b0) stall_seen++;
            i_fetch_stall = 1'($urandom_range(0, 1));
            i_mem_stall = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
        end
        i_fetch_stall = 1'b0; i_mem_stall = 1'b0;
        total++; if (stall_seen != 0) begin bad++; $display("FAIL bg_stall got=%0d need=0", stall_seen); end
        total++; if (busy_cycles != 33) begin bad++; $display("FAIL bg_busy_cycles got=%0d need=33", busy_cycles); end
        do_op(IMDOP_MFHI, 0, 0, st);
        got_hi = o_rd_val;
        do_op(IMDOP_MFLO, 0, 0, st);
        total++; if (got_hi !== 32'd2 || o_rd_val !== 32'd14) begin
            bad++; $display("FAIL bg_divu got hi=%h lo=%h need 2/14", got_hi, o_rd_val); end
        m_hi = 32'd2; m_lo = 32'd14;
    endtask

    task automatic test_back_to_back();
        int st;
        logic [31:0] a, b, c, d, got_hi;
        a = $urandom; b = $urandom; c = $urandom; d = $urandom_range(1, 1000);
        do_op(IMDOP_MULT, a, b, st);
        do_op(IMDOP_DIVU, c, d, st);
        total++; if (st != 33) begin bad++; $display("FAIL b2b_stall got=%0d need=33", st); end
        model_apply(IMDOP_MULT, a, b);
        model_apply(IMDOP_DIVU, c, d);
        do_op(IMDOP_MFHI, 0, 0, st);
        total++; if (st != 33) begin bad++; $display("FAIL b2b_mfhi_stall got=%0d need=33", st); end
        got_hi = o_rd_val;
        do_op(IMDOP_MFLO, 0, 0, st);
        total++; if (got_hi !== m_hi || o_rd_val !== m_lo) begin
            bad++; $display("FAIL b2b_result got hi=%h lo=%h need hi=%h lo=%h", got_hi, o_rd_val, m_hi, m_lo); end
    endtask

    task automatic test_random();
        logic [3:0] ops [6] = '{IMDOP_MULT, IMDOP_MULTU, IMDOP_DIV, IMDOP_DIVU, IMDOP_MTHI, IMDOP_MTLO};
        logic [3:0] op;
        logic [31:0] a, b, got_hi;
        int st;
        for (int n = 0; n < 40; n++) begin
            op = ops[$urandom_range(0, 5)];
            a = pick_val(); b = pick_val();
            do_op(op, a, b, st);
            model_apply(op, a, b);
            do_op(IMDOP_MFHI, 0, 0, st);
            got_hi = o_rd_val;
            do_op(IMDOP_MFLO, 0, 0, st);
            total++; if (got_hi !== m_hi || o_rd_val !== m_lo || o_rd_valid !== 1'b1) begin
                bad++; $display("FAIL rand_%0d op=%0d a=%h b=%h got hi=%h lo=%h need hi=%h lo=%h",
                                n, op, a, b, got_hi, o_rd_val, m_hi, m_lo); end
        end
    endtask

    task automatic test_reset_mid_op();
        int st;
        logic [31:0] got_hi;
        do_op(IMDOP_DIV, 32'h7FFF_0000, 32'd3, st);
        repeat (10) @(negedge clk);
        i_op = IMDOP_MFLO; nrst = 1'b0;
        #1;
        total++; if (o_busy !== 1'b0 || o_stall !== 1'b0 || o_rd_valid !== 1'b0) begin
            bad++; $display("FAIL midreset got busy=%b stall=%b valid=%b need 0/0/0", o_busy, o_stall, o_rd_valid); end
        @(negedge clk);
        nrst = 1'b1; i_op = IMDOP_NONE;
        m_hi = '0; m_lo = '0;
        repeat (40) @(negedge clk);
        do_op(IMDOP_MFHI, 0, 0, st);
        got_hi = o_rd_val;
        do_op(IMDOP_MFLO, 0, 0, st);
        total++; if (got_hi !== 32'h0 || o_rd_val !== 32'h0 || st != 0) begin
            bad++; $display("FAIL midreset_hilo got hi=%h lo=%h stall=%0d need 0/0/0", got_hi, o_rd_val, st); end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_directed();
        test_mthi_mfhi_stall();
        test_divu_background();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
